// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state encoding.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice, reused once per nibble pass.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded from cin directly so no bit waits on its neighbour.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract done four bits per clock through one CLA slice,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

    state_t               state;
    logic [WIDTH-1:0]     a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [WIDTH-1:0]     sum_sh;
    logic [WIDTH-1:0]     sum_next;
    logic                 carry_r;
    logic [CNT_W-1:0]     cnt;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_cout;
    logic                 accept;

    // DONE forwards out_ready so a new operation can be taken on the retiring edge.
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    cla4_slice u_slice (
        .a    (a_sh[NIBBLE_W-1:0]),
        .b    (b_sh[NIBBLE_W-1:0]),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_next = slice_sum;
        end else begin : g_multi
            assign sum_next = {slice_sum, sum_sh[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    // Subtract is A + ~B + 1, so the inverted operand and forced carry are set at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry_r  <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> NIBBLE_W;
                    b_sh    <= b_sh >> NIBBLE_W;
                    sum_sh  <= sum_next;
                    carry_r <= slice_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state    <= DONE;
                        out_sum  <= sum_next;
                        out_cout <= slice_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= in_valid ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                a_sh    <= in_a;
                b_sh    <= in_sub ? ~in_b : in_b;
                carry_r <= in_sub ? 1'b1 : in_cin;
                cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised checks of nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accept edge until out_valid rises, bounded.
    task automatic waitResult(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sub, output int edges);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waitResult(edges);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] exp_sum, input logic exp_cout);
        int edges;
        applyStimulus(a, b, cin, sub, edges);
        checkOutput({tag, "_lat"}, 32'(edges), 32'd4);
        checkOutput({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
        checkOutput({tag, "_inrdy_bp"}, 32'(in_ready), 32'd0);
        consume(tag);
    endtask

    initial begin
        int          edges;
        int          stale;
        logic [15:0] ra, rb;
        logic        rcin, rsub;
        logic [16:0] ref_add;
        logic [15:0] ref_sum;
        logic        ref_cout;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
        checkOutput("rst_out_cout", 32'(out_cout), 32'd0);

        runOp("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        runOp("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        runOp("add_cin",  16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);
        runOp("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        runOp("sub_cinx", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
        runOp("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        runOp("sub_eq",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1);

        // Backpressure, then simultaneous retire and accept.
        applyStimulus(16'h1000, 16'h0234, 1'b0, 1'b0, edges);
        checkOutput("bp_lat", 32'(edges), 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_sum_hold", 32'(out_sum), 32'h1234);
            checkOutput("bp_cout_hold", 32'(out_cout), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        in_a = 16'h00FF; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        #1;
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("b2b_run_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b_run_ready", 32'(in_ready), 32'd0);
        waitResult(edges);
        checkOutput("b2b_lat", 32'(edges), 32'd4);
        checkOutput("b2b_sum", 32'(out_sum), 32'h0100);
        checkOutput("b2b_cout", 32'(out_cout), 32'd0);
        consume("b2b");

        // Reset in the middle of an operation.
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_sum", 32'(out_sum), 32'd0);
        tick();
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) stale++;
        end
        checkOutput("mid_rst_no_stale", 32'(stale), 32'd0);
        runOp("post_rst", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0);

        // in_valid held through RUN with shifting operands must not be captured.
        in_a = 16'h0100; in_b = 16'h0023; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
            tick();
        end
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_sum", 32'(out_sum), 32'h0123);
        checkOutput("hold_cout", 32'(out_cout), 32'd0);
        in_valid = 1'b0;
        consume("hold");

        // Randomised sweep against a 17-bit reference.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rcin = 1'($urandom); rsub = 1'($urandom);
            if (i == 0) rb = ra;
            if (rsub) begin
                ref_sum  = ra - rb;
                ref_cout = (ra >= rb);
            end else begin
                ref_add  = 17'(ra) + 17'(rb) + 17'(rcin);
                ref_sum  = ref_add[15:0];
                ref_cout = ref_add[16];
            end
            runOp("rand", ra, rb, rcin, rsub, ref_sum, ref_cout);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
